// File: rtl/stepper_pkg.sv
// ---------------------------------------------------------------------------
// stepper_pkg
//
// Shared definitions for the floppy head-step sequencer slice.
//   stepState_t        : controller state encoding (IDLE/SETUP/PULSE/GAP/SETTLE)
//   DEFAULT_CNT_W      : default width of step count / completed-step counter
//   DEFAULT_TMR_W      : default width of the pulse/gap/settle tick registers
//   DEFAULT_RECAL_MAX  : default number of steps tried during recalibrate
//   dwellTicks()       : effective dwell length of a timed state (0 acts as 1)
// ---------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_SETTLE = 3'd4
    } stepState_t;

    localparam int DEFAULT_CNT_W     = 8;
    localparam int DEFAULT_TMR_W     = 8;
    localparam int DEFAULT_RECAL_MAX = 255;

    // A programmed dwell of zero ticks still has to wait for one TICK,
    // otherwise a state could be entered and left without any timebase
    // strobe in between.  Values are handled one bit wider than the
    // timer registers so a full-scale setting compares cleanly.
    function automatic logic [DEFAULT_TMR_W:0] dwellTicks(input logic [DEFAULT_TMR_W-1:0] value);
        logic [DEFAULT_TMR_W:0] result;
        result = {1'b0, value};
        if (value == '0) begin
            result = {{DEFAULT_TMR_W{1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/step_sequencer_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
//
// Counts TICK strobes since the owning state was entered and flags the
// strobe that completes the programmed dwell.  One instance serves every
// timed state of the step sequencer.
//
// The counter clears itself on the expiring strobe, and every timed state
// of the sequencer is left exactly on that strobe, so the next state always
// starts from zero without a separate load pulse.  While the sequencer is
// idle the counter is held clear, which covers entry from IDLE and abort.
//
// Ports:
//   CLK       in   system clock
//   RESET     in   synchronous active-high reset
//   i_clear   in   hold the count at zero (sequencer idle)
//   i_tick    in   one-CLK timebase strobe
//   i_target  in   dwell length in ticks, 0 treated as 1
//   o_expire  out  high in the CLK cycle whose TICK completes the dwell
// ---------------------------------------------------------------------------
module tick_timer
    import stepper_pkg::*;
#(
    parameter int TMR_W = DEFAULT_TMR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [TMR_W-1:0] i_target,
    output logic             o_expire
);

    logic [TMR_W-1:0] r_count;
    logic [TMR_W:0]   w_nextCount;
    logic [TMR_W:0]   w_limit;

    // Effective dwell: zero behaves as one tick.
    assign w_limit     = (i_target == '0) ? (TMR_W+1)'(1) : {1'b0, i_target};
    assign w_nextCount = {1'b0, r_count} + (TMR_W+1)'(1);

    // The dwell ends on the strobe that brings the elapsed count up to the
    // limit; the comparison uses the incremented count so that strobe is
    // recognised in the same cycle it arrives.
    assign o_expire = !i_clear && i_tick && (w_nextCount >= w_limit);

    // Elapsed-tick counter.  It never exceeds limit-1, so it cannot wrap.
    always_ff @(posedge CLK) begin
        if (RESET || i_clear || o_expire) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// Floppy head-step controller.  Takes a step command from the host register
// file (step count + direction, or recalibrate-to-track-0), and drives the
// drive's STEP/DIR pins with programmable pulse width, inter-step gap and
// post-seek settle time, all measured in TICK strobes.  Reports busy/done,
// the number of pulses issued and why the command ended.
//
// Ports:
//   CLK           in   system clock
//   RESET         in   synchronous active-high reset
//   TICK          in   one-CLK timebase strobe
//   CMD_WRITE     in   command strobe, honoured only while idle
//   CMD_DIR       in   direction, 1 = out toward track 0
//   CMD_RECAL     in   recalibrate (direction/count ignored)
//   CMD_COUNT     in   number of steps
//   ABORT         in   cancel the running command
//   PULSE_TICKS   in   STEP low time
//   GAP_TICKS     in   STEP high time between pulses
//   SETTLE_TICKS  in   wait after the last step before done
//   TRACK0_IN     in   head is over track 0 (already synchronised)
//   STEP_OUT_n    out  step pulse to drive, active low
//   DIR_OUT       out  direction to drive
//   BUSY          out  command in progress
//   DONE          out  one-CLK pulse on return to idle
//   STEPS_TAKEN   out  pulses issued by the current/last command
//   T0_STOP       out  last command was stopped by the track-0 guard
//   RECAL_ERR     out  recalibrate ran out of steps before track 0
//   ABORTED       out  last command ended by ABORT
// ---------------------------------------------------------------------------
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int TMR_W     = DEFAULT_TMR_W,
    parameter int RECAL_MAX = DEFAULT_RECAL_MAX
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic             CMD_WRITE,
    input  logic             CMD_DIR,
    input  logic             CMD_RECAL,
    input  logic [CNT_W-1:0] CMD_COUNT,
    input  logic             ABORT,
    input  logic [TMR_W-1:0] PULSE_TICKS,
    input  logic [TMR_W-1:0] GAP_TICKS,
    input  logic [TMR_W-1:0] SETTLE_TICKS,
    input  logic             TRACK0_IN,
    output logic             STEP_OUT_n,
    output logic             DIR_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] STEPS_TAKEN,
    output logic             T0_STOP,
    output logic             RECAL_ERR,
    output logic             ABORTED
);

    localparam logic [CNT_W-1:0] RECAL_LOAD = CNT_W'(RECAL_MAX);

    stepState_t       r_state;
    logic             r_stepN;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_stepsTaken;
    logic             r_t0Stop;
    logic             r_recalErr;
    logic             r_aborted;
    logic [CNT_W-1:0] r_remaining;
    logic             r_recal;
    logic [TMR_W-1:0] r_dwell;

    logic             w_expire;
    logic             w_timerClear;
    logic             w_guardStop;
    logic [CNT_W-1:0] w_stepsInc;
    logic [CNT_W-1:0] w_remainingDec;

    // The timer only runs while a command is active; in IDLE it is held
    // at zero so the first timed state of a command starts cleanly.
    assign w_timerClear = (r_state == ST_IDLE);

    // Track-0 guard: stepping outward while already on track 0 would drive
    // the head against its mechanical stop.
    assign w_guardStop = r_dir && TRACK0_IN;

    // Both counters saturate instead of wrapping.
    assign w_stepsInc     = (r_stepsTaken == '1) ? r_stepsTaken : r_stepsTaken + CNT_W'(1);
    assign w_remainingDec = (r_remaining == '0) ? r_remaining : r_remaining - CNT_W'(1);

    // Dwell timer shared by SETUP, PULSE, GAP and SETTLE.  r_dwell is
    // captured on entry to each timed state so later changes on the timing
    // inputs cannot stretch or shorten a dwell already in progress.
    tick_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_clear  (w_timerClear),
        .i_tick   (TICK),
        .i_target (r_dwell),
        .o_expire (w_expire)
    );

    // Main sequencer.  Every output is a register written here.  ABORT is
    // checked before any timer-driven transition so it wins a coincident
    // TICK; a pulse cut short by ABORT still counts as issued, because the
    // drive has already seen the falling STEP edge.  The guard is evaluated
    // both after the SETUP dwell and after every non-final GAP, i.e. right
    // before each pulse would start.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_stepN      <= 1'b1;
            r_dir        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_stepsTaken <= '0;
            r_t0Stop     <= 1'b0;
            r_recalErr   <= 1'b0;
            r_aborted    <= 1'b0;
            r_remaining  <= '0;
            r_recal      <= 1'b0;
            r_dwell      <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && ABORT) begin
                if (r_state == ST_PULSE) begin
                    r_stepsTaken <= w_stepsInc;
                end
                r_state   <= ST_IDLE;
                r_stepN   <= 1'b1;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (CMD_WRITE) begin
                            r_dir        <= CMD_RECAL ? 1'b1 : CMD_DIR;
                            r_recal      <= CMD_RECAL;
                            r_remaining  <= CMD_RECAL ? RECAL_LOAD : CMD_COUNT;
                            r_stepsTaken <= '0;
                            r_t0Stop     <= 1'b0;
                            r_recalErr   <= 1'b0;
                            r_aborted    <= 1'b0;
                            r_busy       <= 1'b1;
                            if (!CMD_RECAL && CMD_COUNT == '0) begin
                                r_state <= ST_SETTLE;
                                r_dwell <= SETTLE_TICKS;
                            end else begin
                                r_state <= ST_SETUP;
                                r_dwell <= TMR_W'(1);
                            end
                        end
                    end

                    ST_SETUP: begin
                        if (w_expire) begin
                            if (w_guardStop) begin
                                r_state <= ST_SETTLE;
                                r_dwell <= SETTLE_TICKS;
                                if (!r_recal) begin
                                    r_t0Stop <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_PULSE;
                                r_stepN <= 1'b0;
                                r_dwell <= PULSE_TICKS;
                            end
                        end
                    end

                    ST_PULSE: begin
                        if (w_expire) begin
                            r_state      <= ST_GAP;
                            r_stepN      <= 1'b1;
                            r_remaining  <= w_remainingDec;
                            r_stepsTaken <= w_stepsInc;
                            r_dwell      <= GAP_TICKS;
                        end
                    end

                    ST_GAP: begin
                        if (w_expire) begin
                            if (r_remaining == '0) begin
                                r_state <= ST_SETTLE;
                                r_dwell <= SETTLE_TICKS;
                                if (r_recal && !TRACK0_IN) begin
                                    r_recalErr <= 1'b1;
                                end
                            end else if (w_guardStop) begin
                                r_state <= ST_SETTLE;
                                r_dwell <= SETTLE_TICKS;
                                if (!r_recal) begin
                                    r_t0Stop <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_PULSE;
                                r_stepN <= 1'b0;
                                r_dwell <= PULSE_TICKS;
                            end
                        end
                    end

                    ST_SETTLE: begin
                        if (w_expire) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_stepN <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign STEP_OUT_n  = r_stepN;
    assign DIR_OUT     = r_dir;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign STEPS_TAKEN = r_stepsTaken;
    assign T0_STOP     = r_t0Stop;
    assign RECAL_ERR   = r_recalErr;
    assign ABORTED     = r_aborted;

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
//
// Drives step commands into step_sequencer and compares the observed STEP
// waveform and status against outcomes computed from the command rules:
// a pulse train whose edges fall on fixed tick offsets, a pulse count set by
// the step limit and the track-0 position, and the resulting flags.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

    localparam int CNT_W        = 8;
    localparam int TMR_W        = 8;
    localparam int RECAL_MAX    = 20;
    localparam int NEVER        = 100000;
    localparam int CYCLE_BUDGET = 20000;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             TICK;
    logic             CMD_WRITE;
    logic             CMD_DIR;
    logic             CMD_RECAL;
    logic [CNT_W-1:0] CMD_COUNT;
    logic             ABORT;
    logic [TMR_W-1:0] PULSE_TICKS;
    logic [TMR_W-1:0] GAP_TICKS;
    logic [TMR_W-1:0] SETTLE_TICKS;
    logic             TRACK0_IN;
    logic             STEP_OUT_n;
    logic             DIR_OUT;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] STEPS_TAKEN;
    logic             T0_STOP;
    logic             RECAL_ERR;
    logic             ABORTED;

    int checks = 0;
    int errors = 0;

    step_sequencer #(
        .CNT_W     (CNT_W),
        .TMR_W     (TMR_W),
        .RECAL_MAX (RECAL_MAX)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .TICK         (TICK),
        .CMD_WRITE    (CMD_WRITE),
        .CMD_DIR      (CMD_DIR),
        .CMD_RECAL    (CMD_RECAL),
        .CMD_COUNT    (CMD_COUNT),
        .ABORT        (ABORT),
        .PULSE_TICKS  (PULSE_TICKS),
        .GAP_TICKS    (GAP_TICKS),
        .SETTLE_TICKS (SETTLE_TICKS),
        .TRACK0_IN    (TRACK0_IN),
        .STEP_OUT_n   (STEP_OUT_n),
        .DIR_OUT      (DIR_OUT),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .STEPS_TAKEN  (STEPS_TAKEN),
        .T0_STOP      (T0_STOP),
        .RECAL_ERR    (RECAL_ERR),
        .ABORTED      (ABORTED)
    );

    // Free-running clock; inputs change on the falling edge and outputs are
    // sampled there too, half a period away from the active edge.
    always #5 CLK = ~CLK;

    // One comparison: counts it, and reports tag/observed/expected on error.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Loads the command/timing inputs for the next active edge.
    task automatic applyStimulus(input bit write, input bit recal, input bit dir,
                                 input int count, input int p, input int g, input int s);
        CMD_WRITE    = write;
        CMD_RECAL    = recal;
        CMD_DIR      = dir;
        CMD_COUNT    = CNT_W'(count);
        PULSE_TICKS  = TMR_W'(p);
        GAP_TICKS    = TMR_W'(g);
        SETTLE_TICKS = TMR_W'(s);
    endtask

    // Randomised timebase: strobe with probability 1/period.
    task automatic randomTick(input int period);
        TICK = ($urandom_range(period - 1) == 0);
    endtask

    // Advances through one active edge; reports whether TICK was sampled
    // there, and returns at the following falling edge.
    task automatic stepClock(output bit ticked);
        @(posedge CLK);
        ticked = TICK;
        @(negedge CLK);
    endtask

    // Issues one command and follows it to DONE.  Expected behaviour:
    //   limit   = RECAL_MAX for recalibrate, otherwise CMD_COUNT
    //   pulses  = limit, cut to t0After when track 0 is reached first
    //             (only relevant when moving outward or recalibrating)
    //   pulse k falls at tick 1 + k*(p+g) and rises p ticks later
    //   DONE at tick s for a zero-count seek, else 1 + pulses*(p+g) + s
    // with p/g/s being the programmed values, zero counting as one.
    task automatic runCommand(input string name, input bit recal, input bit dir, input int count,
                              input int p, input int g, input int s, input int t0After,
                              input int tickPeriod);
        int  pp, gg, ss, limit, expPulses, expDone, tickIdx, falls, rises;
        bit  expT0, expErr, ticked, doneSeen, prevStep;

        pp = (p == 0) ? 1 : p;
        gg = (g == 0) ? 1 : g;
        ss = (s == 0) ? 1 : s;
        expT0  = 1'b0;
        expErr = 1'b0;
        if (!recal && count == 0) begin
            expPulses = 0;
            expDone   = ss;
        end else begin
            limit = recal ? RECAL_MAX : count;
            expPulses = ((recal || dir) && t0After < limit) ? t0After : limit;
            expT0     = !recal && dir && (t0After < limit);
            expErr    = recal && (t0After > limit);
            expDone   = 1 + expPulses * (pp + gg) + ss;
        end

        TRACK0_IN = (t0After == 0);
        applyStimulus(1'b1, recal, dir, count, p, g, s);
        randomTick(tickPeriod);
        stepClock(ticked);
        CMD_WRITE = 1'b0;
        checkOutput({name, ".busy"}, int'(BUSY), 1);
        checkOutput({name, ".dir"}, int'(DIR_OUT), int'(recal ? 1'b1 : dir));

        tickIdx  = 0;
        falls    = 0;
        rises    = 0;
        doneSeen = 1'b0;
        prevStep = STEP_OUT_n;
        for (int cyc = 0; cyc < CYCLE_BUDGET && !doneSeen; cyc++) begin
            randomTick(tickPeriod);
            stepClock(ticked);
            if (ticked) tickIdx++;
            if (prevStep && !STEP_OUT_n) begin
                checkOutput({name, ".fallTick"}, tickIdx, 1 + falls * (pp + gg));
                falls++;
            end
            if (!prevStep && STEP_OUT_n) begin
                checkOutput({name, ".riseTick"}, tickIdx, 1 + rises * (pp + gg) + pp);
                rises++;
                if (rises == t0After) TRACK0_IN = 1'b1;
            end
            prevStep = STEP_OUT_n;
            if (DONE) begin
                doneSeen = 1'b1;
                checkOutput({name, ".doneTick"}, tickIdx, expDone);
            end
        end
        checkOutput({name, ".doneSeen"}, int'(doneSeen), 1);
        checkOutput({name, ".pulses"}, falls, expPulses);
        checkOutput({name, ".stepsTaken"}, int'(STEPS_TAKEN), expPulses);
        checkOutput({name, ".t0Stop"}, int'(T0_STOP), int'(expT0));
        checkOutput({name, ".recalErr"}, int'(RECAL_ERR), int'(expErr));
        checkOutput({name, ".aborted"}, int'(ABORTED), 0);
        checkOutput({name, ".busyDone"}, int'(BUSY), 0);
        checkOutput({name, ".stepIdle"}, int'(STEP_OUT_n), 1);

        TICK = 1'b0;
        stepClock(ticked);
        checkOutput({name, ".donePulse"}, int'(DONE), 0);
    endtask

    // Directed scenarios followed by randomised commands.
    initial begin
        bit ticked;
        int falls;
        int doneCount;
        bit prevStep;
        bit aborting;

        RESET     = 1'b1;
        TICK      = 1'b0;
        ABORT     = 1'b0;
        TRACK0_IN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1, 1, 1);
        @(negedge CLK);
        stepClock(ticked);
        stepClock(ticked);
        RESET = 1'b0;
        checkOutput("reset.step", int'(STEP_OUT_n), 1);
        checkOutput("reset.dir", int'(DIR_OUT), 1);
        checkOutput("reset.busy", int'(BUSY), 0);
        checkOutput("reset.done", int'(DONE), 0);
        checkOutput("reset.steps", int'(STEPS_TAKEN), 0);
        checkOutput("reset.flags", int'({T0_STOP, RECAL_ERR, ABORTED}), 0);

        runCommand("basic", 1'b0, 1'b0, 3, 2, 3, 4, NEVER, 4);
        runCommand("t0guard", 1'b0, 1'b1, 10, 2, 2, 3, 4, 2);
        runCommand("recal7", 1'b1, 1'b0, 3, 1, 2, 2, 7, 2);
        runCommand("recalFail", 1'b1, 1'b0, 0, 0, 0, 0, NEVER, 1);
        runCommand("recalAtLimit", 1'b1, 1'b1, 0, 1, 1, 1, RECAL_MAX, 1);
        runCommand("recalAtT0", 1'b1, 1'b0, 5, 2, 2, 2, 0, 2);
        runCommand("count0", 1'b0, 1'b1, 0, 3, 3, 5, 0, 2);
        runCommand("pulse0", 1'b0, 1'b0, 2, 0, 2, 1, NEVER, 3);
        runCommand("t0AfterLast", 1'b0, 1'b1, 3, 1, 1, 1, 3, 1);

        // ABORT while idle must leave the sequencer untouched.
        ABORT = 1'b1;
        stepClock(ticked);
        ABORT = 1'b0;
        checkOutput("idleAbort.busy", int'(BUSY), 0);
        checkOutput("idleAbort.done", int'(DONE), 0);
        checkOutput("idleAbort.aborted", int'(ABORTED), 0);

        // Abort during the second pulse; a write while busy is ignored.
        TRACK0_IN = 1'b0;
        TICK      = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 3, 2, 2);
        stepClock(ticked);
        CMD_WRITE = 1'b0;
        falls    = 0;
        prevStep = STEP_OUT_n;
        aborting = 1'b0;
        for (int cyc = 0; cyc < 200 && !aborting; cyc++) begin
            stepClock(ticked);
            if (prevStep && !STEP_OUT_n) begin
                falls++;
                if (falls == 1) begin
                    applyStimulus(1'b1, 1'b0, 1'b1, 9, 3, 2, 2);
                end
            end else begin
                CMD_WRITE = 1'b0;
            end
            if (falls == 2) aborting = 1'b1;
            prevStep = STEP_OUT_n;
        end
        CMD_WRITE = 1'b0;
        checkOutput("abort.reached", int'(aborting), 1);
        ABORT = 1'b1;
        stepClock(ticked);
        ABORT = 1'b0;
        checkOutput("abort.step", int'(STEP_OUT_n), 1);
        checkOutput("abort.done", int'(DONE), 1);
        checkOutput("abort.aborted", int'(ABORTED), 1);
        checkOutput("abort.busy", int'(BUSY), 0);
        checkOutput("abort.steps", int'(STEPS_TAKEN), 2);
        checkOutput("abort.dirKept", int'(DIR_OUT), 0);
        falls     = 0;
        doneCount = 0;
        prevStep  = STEP_OUT_n;
        for (int cyc = 0; cyc < 40; cyc++) begin
            stepClock(ticked);
            if (prevStep && !STEP_OUT_n) falls++;
            if (DONE || BUSY) doneCount++;
            prevStep = STEP_OUT_n;
        end
        checkOutput("abort.noSettle", doneCount, 0);
        checkOutput("abort.noPulses", falls, 0);

        // Reset in the middle of a pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 4, 3, 2, 2);
        stepClock(ticked);
        CMD_WRITE = 1'b0;
        aborting = 1'b0;
        for (int cyc = 0; cyc < 200 && !aborting; cyc++) begin
            stepClock(ticked);
            if (!STEP_OUT_n) aborting = 1'b1;
        end
        checkOutput("resetMid.reached", int'(aborting), 1);
        RESET = 1'b1;
        stepClock(ticked);
        RESET = 1'b0;
        checkOutput("resetMid.step", int'(STEP_OUT_n), 1);
        checkOutput("resetMid.busy", int'(BUSY), 0);
        checkOutput("resetMid.done", int'(DONE), 0);
        checkOutput("resetMid.steps", int'(STEPS_TAKEN), 0);
        checkOutput("resetMid.dir", int'(DIR_OUT), 1);
        doneCount = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            stepClock(ticked);
            if (DONE || BUSY || !STEP_OUT_n) doneCount++;
        end
        checkOutput("resetMid.quiet", doneCount, 0);

        // Randomised commands.
        for (int k = 0; k < 12; k++) begin
            int t0;
            t0 = ($urandom_range(1) == 0) ? NEVER : int'($urandom_range(14));
            runCommand($sformatf("rand%0d", k), ($urandom_range(3) == 0), 1'($urandom_range(1)),
                       int'($urandom_range(12)), int'($urandom_range(4)), int'($urandom_range(4)),
                       int'($urandom_range(4)), t0, int'($urandom_range(3, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
